// File: rtl/clk_div_pkg.sv
// Shared types, duty-mode encodings and the output-phase helper for the
// runtime-programmable clock divider.
package clk_div_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_e;

    // Duty-mode encodings (3 is reserved and rejected by the controller)
    localparam logic [1:0] DUTY_HALF  = 2'd0;
    localparam logic [1:0] DUTY_PULSE = 2'd1;
    localparam logic [1:0] DUTY_WIDE  = 2'd2;

    // Width used by the helper; callers zero-extend their counter/ratio
    localparam int FN_W = 32;

    // Level of the posedge half of the output for a given counter position.
    // For mode 0, floor(N/2) covers both N/2 (even) and (N-1)/2 (odd); the
    // negedge flop adds the missing half cycle for odd N.
    function automatic logic pos_hi_fn(
        input logic [FN_W-1:0] cnt,
        input logic [FN_W-1:0] div,
        input logic [1:0]      mode
    );
        logic hi;
        case (mode)
            DUTY_HALF:  hi = (cnt < (div >> 1));
            DUTY_PULSE: hi = (cnt == '0);
            DUTY_WIDE:  hi = (cnt != (div - 32'd1));
            default:    hi = 1'b0;
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, posedge/negedge output flops and the
// glitch-free output OR. Ratio and mode are the active configuration; the
// controller only changes them at a wrap or while stopped.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_div,
    input  logic [1:0]       i_duty,
    output logic             o_wrap,
    output logic             o_clk
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pos_hi;
    logic             r_neg_hi;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wrap;
    logic             w_odd_half;

    assign w_wrap     = (r_cnt == (i_div - ONE));
    assign w_odd_half = (i_duty == DUTY_HALF) && i_div[0];

    // Next counter value: hold at 0 when stopped, reload 0 on start or wrap
    always_comb begin
        if (!i_run || i_restart || w_wrap) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + ONE;
        end
    end

    // Counter and posedge output half; pos_hi tracks the value cnt is moving to.
    // At a reconfiguration wrap the old ratio/mode are still on i_div/i_duty,
    // which is harmless: position 0 is high for every legal configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_pos_hi <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_pos_hi <= i_run && pos_hi_fn(FN_W'(w_cnt_next), FN_W'(i_div), i_duty);
        end
    end

    // Negedge half: delays pos_hi by half a cycle only for 50 % duty at odd N
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_hi <= 1'b0;
        end else begin
            r_neg_hi <= w_odd_half ? r_pos_hi : 1'b0;
        end
    end

    assign o_wrap = w_wrap;
    assign o_clk  = r_pos_hi | r_neg_hi;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: sequences start/stop on period boundaries,
// accepts ratio/duty updates over valid/ready and defers them to the next
// boundary while running, and flags illegal configurations.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = 3,
    parameter int DEF_DUTY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [1:0]       cfg_duty,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [1:0]       RST_DUTY = 2'(DEF_DUTY);
    localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_act_div;
    logic [1:0]       r_act_duty;
    logic [CNT_W-1:0] r_shd_div;
    logic [1:0]       r_shd_duty;
    logic             r_cfg_err;

    logic w_hs;
    logic w_legal;
    logic w_take_idle;
    logic w_take_shd;
    logic w_apply_shd;
    logic w_run;
    logic w_restart;
    logic w_wrap;

    assign cfg_ready = (r_state == IDLE) || (r_state == RUN);
    assign w_hs      = cfg_valid && cfg_ready;
    assign w_legal   = (cfg_div >= MIN_DIV) && (cfg_duty != 2'd3);

    // Next state and configuration-routing decisions
    always_comb begin
        w_state_next = r_state;
        w_take_idle  = 1'b0;
        w_take_shd   = 1'b0;
        w_apply_shd  = 1'b0;
        case (r_state)
            IDLE: begin
                w_take_idle = w_hs && w_legal;
                if (en) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_hs && w_legal) begin
                    w_take_shd   = 1'b1;
                    w_state_next = PEND;
                end else if (!en) begin
                    w_state_next = STOP;
                end
            end
            PEND: begin
                if (w_wrap) begin
                    w_apply_shd  = 1'b1;
                    w_state_next = en ? RUN : IDLE;
                end
            end
            STOP: begin
                if (en) begin
                    w_state_next = RUN;
                end else if (w_wrap) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The datapath runs in every cycle whose next state is not IDLE
    assign w_run     = (w_state_next != IDLE);
    assign w_restart = (r_state == IDLE) && w_run;

    // State, active/shadow configuration and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_act_div  <= RST_DIV;
            r_act_duty <= RST_DUTY;
            r_shd_div  <= RST_DIV;
            r_shd_duty <= RST_DUTY;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cfg_err <= w_hs && !w_legal;
            if (w_take_idle) begin
                r_act_div  <= cfg_div;
                r_act_duty <= cfg_duty;
            end else if (w_apply_shd) begin
                r_act_div  <= r_shd_div;
                r_act_duty <= r_shd_duty;
            end
            if (w_take_shd) begin
                r_shd_div  <= cfg_div;
                r_shd_duty <= cfg_duty;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_run),
        .i_restart (w_restart),
        .i_div     (r_act_div),
        .i_duty    (r_act_duty),
        .o_wrap    (w_wrap),
        .o_clk     (clk_out)
    );

    assign cfg_err = r_cfg_err;
    assign busy    = (r_state != IDLE);
    assign cur_div = r_act_div;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: a fixed vector table, directed
// multi-cycle sequences and randomized traffic against a period-level model.
module tb_clk_div_ctrl;

    localparam int CNT_W    = 8;
    localparam int DEF_DIV  = 3;
    localparam int DEF_DUTY = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic [1:0]       cfg_duty;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             busy;
    logic [CNT_W-1:0] cur_div;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_ctrl #(
        .CNT_W    (CNT_W),
        .DEF_DIV  (DEF_DIV),
        .DEF_DUTY (DEF_DUTY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_duty  (cfg_duty),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (period position + flags) ----------
    bit m_active, m_pending, m_stopping, m_err;
    int m_n, m_mode, m_k, m_shd_n, m_shd_mode;

    function automatic bit m_ready();
        return !m_active || (!m_pending && !m_stopping);
    endfunction

    // Number of high half-cycles at the start of each period
    function automatic int m_high_halves();
        if (m_mode == 0) return m_n;
        if (m_mode == 1) return 2;
        return 2 * (m_n - 1);
    endfunction

    // Expected output in half h (0 = after posedge, 1 = after negedge)
    function automatic bit m_clk_half(input int h);
        return m_active && ((2 * m_k + h) < m_high_halves());
    endfunction

    task automatic model_reset();
        m_active   = 1'b0;
        m_pending  = 1'b0;
        m_stopping = 1'b0;
        m_err      = 1'b0;
        m_n        = DEF_DIV;
        m_mode     = DEF_DUTY;
        m_k        = 0;
        m_shd_n    = DEF_DIV;
        m_shd_mode = DEF_DUTY;
    endtask

    task automatic model_edge();
        bit hs, legal, boundary;
        hs    = cfg_valid && m_ready();
        legal = (int'(cfg_div) >= 2) && (int'(cfg_duty) != 3);
        m_err = hs && !legal;
        if (hs)
            $display("cfg %s: div=%0d duty=%0d t=%0t", legal ? "accepted" : "rejected",
                     cfg_div, cfg_duty, $time);
        if (!m_active) begin
            if (hs && legal) begin
                m_n    = int'(cfg_div);
                m_mode = int'(cfg_duty);
            end
            if (en) begin
                m_active = 1'b1;
                m_k      = 0;
            end
        end else begin
            boundary = (m_k == m_n - 1);
            m_k = boundary ? 0 : m_k + 1;
            if (m_pending) begin
                if (boundary) begin
                    m_n       = m_shd_n;
                    m_mode    = m_shd_mode;
                    m_pending = 1'b0;
                    if (!en) m_active = 1'b0;
                end
            end else if (m_stopping) begin
                if (en) begin
                    m_stopping = 1'b0;
                end else if (boundary) begin
                    m_stopping = 1'b0;
                    m_active   = 1'b0;
                end
            end else begin
                if (hs && legal) begin
                    m_shd_n    = int'(cfg_div);
                    m_shd_mode = int'(cfg_duty);
                    m_pending  = 1'b1;
                end else if (!en) begin
                    m_stopping = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cfg_ready", int'(cfg_ready), int'(m_ready()));
        check("busy", int'(busy), int'(m_active));
        check("cur_div", int'(cur_div), m_n);
        check("cfg_err", int'(cfg_err), int'(m_err));
        check("clk_out_h0", int'(clk_out), int'(m_clk_half(0)));
        @(negedge clk);
        #1;
        check("clk_out_h1", int'(clk_out), int'(m_clk_half(1)));
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_cur_div", int'(cur_div), DEF_DIV);
        check("rst_err", int'(cfg_err), 0);
        model_reset();
        en        = 1'b0;
        cfg_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_idle_cfg(input int d, input int m);
        en        = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(d);
        cfg_duty  = 2'(m);
        step();
        cfg_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             en;
        logic             vld;
        logic [CNT_W-1:0] div;
        logic [1:0]       duty;
        logic             rdy;
        logic             bsy;
        int               cur;
        logic             err;
        logic             c0;
        logic             c1;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic e, input logic v, input int d, input int m,
                           input logic rdy, input logic bsy, input int cur,
                           input logic err, input logic c0, input logic c1);
        vec_t t;
        t.en = e; t.vld = v; t.div = CNT_W'(d); t.duty = 2'(m);
        t.rdy = rdy; t.bsy = bsy; t.cur = cur; t.err = err; t.c0 = c0; t.c1 = c1;
        vq.push_back(t);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_duty  = '0;
        model_reset();

        //       en vld div duty | rdy bsy cur err c0 c1
        add_vec(0, 0, 0, 0,   1, 0, 3, 0, 0, 0);  // idle
        add_vec(1, 0, 0, 0,   1, 1, 3, 0, 1, 1);  // start, cnt 0
        add_vec(1, 0, 0, 0,   1, 1, 3, 0, 1, 0);  // cnt 1: high first half
        add_vec(1, 0, 0, 0,   1, 1, 3, 0, 0, 0);  // cnt 2
        add_vec(1, 1, 1, 0,   1, 1, 3, 1, 1, 1);  // div=1 rejected
        add_vec(1, 0, 0, 0,   1, 1, 3, 0, 1, 0);  // pulse lasts one cycle
        add_vec(1, 1, 5, 3,   1, 1, 3, 1, 0, 0);  // duty=3 rejected
        add_vec(1, 0, 0, 0,   1, 1, 3, 0, 1, 1);
        add_vec(0, 0, 0, 0,   0, 1, 3, 0, 1, 0);  // stop requested
        add_vec(0, 0, 0, 0,   0, 1, 3, 0, 0, 0);  // final period completes
        add_vec(0, 0, 0, 0,   1, 0, 3, 0, 0, 0);  // boundary -> idle
        add_vec(0, 1, 4, 1,   1, 0, 4, 0, 0, 0);  // idle config N=4 pulse
        add_vec(1, 0, 0, 0,   1, 1, 4, 0, 1, 1);
        add_vec(1, 0, 0, 0,   1, 1, 4, 0, 0, 0);
        add_vec(1, 0, 0, 0,   1, 1, 4, 0, 0, 0);
        add_vec(1, 0, 0, 0,   1, 1, 4, 0, 0, 0);
        add_vec(1, 0, 0, 0,   1, 1, 4, 0, 1, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(cfg_ready), 1);
        check("reset_cur_div", int'(cur_div), DEF_DIV);
        check("reset_err", int'(cfg_err), 0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            en        = vq[i].en;
            cfg_valid = vq[i].vld;
            cfg_div   = vq[i].div;
            cfg_duty  = vq[i].duty;
            @(posedge clk);
            model_edge();
            #1;
            check("vec_ready", int'(cfg_ready), int'(vq[i].rdy));
            check("vec_busy", int'(busy), int'(vq[i].bsy));
            check("vec_cur_div", int'(cur_div), vq[i].cur);
            check("vec_err", int'(cfg_err), int'(vq[i].err));
            check("vec_clk_h0", int'(clk_out), int'(vq[i].c0));
            @(negedge clk);
            #1;
            check("vec_clk_h1", int'(clk_out), int'(vq[i].c1));
            $display("vec %0d: en=%0b vld=%0b div=%0d duty=%0d -> rdy=%0b busy=%0b cur=%0d err=%0b clk=%0b%0b",
                     i, vq[i].en, vq[i].vld, vq[i].div, vq[i].duty,
                     cfg_ready, busy, cur_div, cfg_err, vq[i].c0, clk_out);
        end
        cfg_valid = 1'b0;

        // Reconfigure N=4 mode 0 -> N=5 mode 1 while running, offered at cnt 1
        do_reset();
        send_idle_cfg(4, 0);
        en = 1'b1;
        step();                 // cnt 0
        step();                 // cnt 1
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(5);
        cfg_duty  = 2'd1;
        step();                 // accepted, pending
        cfg_valid = 1'b0;
        check("pend_ready_low", int'(cfg_ready), 0);
        repeat (12) step();
        check("reconf_cur_div", int'(cur_div), 5);
        $display("seq reconfig 4->5 done");

        // N=6 mode 2, drop en at cnt 2: final period completes, then idle
        do_reset();
        send_idle_cfg(6, 2);
        en = 1'b1;
        repeat (3) step();      // cnt 0..2
        en = 1'b0;
        repeat (8) step();
        check("stop_busy", int'(busy), 0);
        check("stop_clk_out", int'(clk_out), 0);
        $display("seq stop N=6 done");

        // N=7 mode 0 from idle: 3.5 high / 3.5 low
        do_reset();
        send_idle_cfg(7, 0);
        en = 1'b1;
        repeat (16) step();
        $display("seq N=7 half duty done");

        // Reset while a configuration is pending and the output is high
        do_reset();
        send_idle_cfg(4, 0);
        en = 1'b1;
        repeat (4) step();      // cnt 0..3
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(3);
        cfg_duty  = 2'd2;
        step();                 // accepted at boundary; cnt 0 of next period
        cfg_valid = 1'b0;
        check("pend_clk_high", int'(clk_out), 1);
        check("pend_ready", int'(cfg_ready), 0);
        do_reset();
        en = 1'b1;
        repeat (8) step();      // default N=3 mode 0, shadow discarded
        $display("seq reset during pend done");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = CNT_W'($urandom_range(0, 9));
            cfg_duty  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
